// File: rtl/cpsr_unit_if.sv
// Bundle of issue/writeback/MSR/exception controls and CPSR status outputs for cpsr_unit.
interface cpsr_unit_if;
  logic        issue_set_flags;
  logic        wb_flags_valid;
  logic [3:0]  wb_flags;
  logic [3:0]  wb_mask;
  logic        msr_valid;
  logic        msr_spsr;
  logic [3:0]  msr_field;
  logic [31:0] msr_data;
  logic        spsr_restore;
  logic        exc_valid;
  logic [4:0]  exc_mode;
  logic        flush;
  logic [31:0] cpsr;
  logic [31:0] spsr;
  logic        flags_ready;
  logic        issue_stall;

  modport master (
    output issue_set_flags, wb_flags_valid, wb_flags, wb_mask,
           msr_valid, msr_spsr, msr_field, msr_data,
           spsr_restore, exc_valid, exc_mode, flush,
    input  cpsr, spsr, flags_ready, issue_stall
  );

  modport slave (
    input  issue_set_flags, wb_flags_valid, wb_flags, wb_mask,
           msr_valid, msr_spsr, msr_field, msr_data,
           spsr_restore, exc_valid, exc_mode, flush,
    output cpsr, spsr, flags_ready, issue_stall
  );
endinterface

// File: rtl/cpsr_unit.sv
// Architectural CPSR/SPSR holder with flag writeback, MSR, exception entry/return,
// and an in-flight flag-writer counter driving flags_ready / issue_stall.
module cpsr_unit #(
  parameter int unsigned MAX_PENDING = 3,
  parameter logic [4:0]  RESET_MODE  = 5'b10011
) (
  input logic         clk,
  input logic         rst_n,
  cpsr_unit_if.slave  bus
);
  localparam int unsigned     PW    = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0]   P_MAX = PW'(MAX_PENDING);
  localparam logic [31:0]     CPSR_RST = {24'b0, 1'b1, 1'b1, 1'b0, RESET_MODE};

  logic [31:0]   cpsr_q, cpsr_d;
  logic [31:0]   spsr_q, spsr_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [31:0]   step;
  logic          inc, dec;

  // Each stage overwrites the previous one's result: writeback, MSR, restore, exception.
  always_comb begin
    step = cpsr_q;
    if (bus.wb_flags_valid) begin
      for (int unsigned i = 0; i < 4; i++)
        if (bus.wb_mask[i]) step[28+i] = bus.wb_flags[i];
    end
    if (bus.msr_valid && !bus.msr_spsr) begin
      for (int unsigned b = 0; b < 4; b++)
        if (bus.msr_field[b]) step[8*b +: 8] = bus.msr_data[8*b +: 8];
    end
    if (bus.spsr_restore) step = spsr_q;

    spsr_d = spsr_q;
    if (bus.msr_valid && bus.msr_spsr) begin
      for (int unsigned b = 0; b < 4; b++)
        if (bus.msr_field[b]) spsr_d[8*b +: 8] = bus.msr_data[8*b +: 8];
    end

    cpsr_d = step;
    if (bus.exc_valid) begin
      spsr_d      = step;
      cpsr_d[4:0] = bus.exc_mode;
      cpsr_d[7]   = 1'b1;
      cpsr_d[5]   = 1'b0;
    end
  end

  // A stalled issue does not count, so a concurrent writeback still decrements.
  always_comb begin
    inc       = bus.issue_set_flags && (pending_q != P_MAX);
    dec       = bus.wb_flags_valid;
    pending_d = pending_q;
    if (bus.flush || bus.exc_valid)
      pending_d = '0;
    else if (inc && !dec)
      pending_d = pending_q + 1'b1;
    else if (dec && !inc && (pending_q != '0))
      pending_d = pending_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr_q    <= CPSR_RST;
      spsr_q    <= '0;
      pending_q <= '0;
    end else begin
      cpsr_q    <= cpsr_d;
      spsr_q    <= spsr_d;
      pending_q <= pending_d;
    end
  end

  assign bus.cpsr        = cpsr_q;
  assign bus.spsr        = spsr_q;
  assign bus.flags_ready = (pending_q == '0);
  assign bus.issue_stall = (pending_q == P_MAX);
endmodule

// File: tb/tb_cpsr_unit.sv
// Directed self-checking bench for cpsr_unit.
module tb_cpsr_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  cpsr_unit_if bus ();

  cpsr_unit #(.MAX_PENDING(3), .RESET_MODE(5'b10011)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.issue_set_flags = 1'b0;
    bus.wb_flags_valid  = 1'b0;
    bus.wb_flags        = 4'h0;
    bus.wb_mask         = 4'h0;
    bus.msr_valid       = 1'b0;
    bus.msr_spsr        = 1'b0;
    bus.msr_field       = 4'h0;
    bus.msr_data        = 32'h0;
    bus.spsr_restore    = 1'b0;
    bus.exc_valid       = 1'b0;
    bus.exc_mode        = 5'h0;
    bus.flush           = 1'b0;
  endtask

  // Apply current inputs across one rising edge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++; if (bus.cpsr !== 32'h0000_00D3) begin errors++; $display("FAIL reset_cpsr got=%h exp=%h", bus.cpsr, 32'h0000_00D3); end
    checks++; if (bus.spsr !== 32'h0) begin errors++; $display("FAIL reset_spsr got=%h exp=0", bus.spsr); end
    checks++; if (bus.flags_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.flags_ready); end
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.issue_stall); end
  endtask

  task automatic test_masked_wb();
    bus.issue_set_flags = 1'b1; tick();
    checks++; if (bus.flags_ready !== 1'b0) begin errors++; $display("FAIL mwb_ready_busy got=%b exp=0", bus.flags_ready); end
    bus.wb_flags_valid = 1'b1; bus.wb_flags = 4'b1111; bus.wb_mask = 4'b1110; tick();
    checks++; if (bus.cpsr !== 32'hE000_00D3) begin errors++; $display("FAIL mwb_cpsr got=%h exp=%h", bus.cpsr, 32'hE000_00D3); end
    checks++; if (bus.flags_ready !== 1'b1) begin errors++; $display("FAIL mwb_ready got=%b exp=1", bus.flags_ready); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      bus.issue_set_flags = 1'b1; tick();
    end
    checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL sat_stall got=%b exp=1", bus.issue_stall); end
    bus.issue_set_flags = 1'b1; bus.wb_flags_valid = 1'b1; bus.wb_mask = 4'b0000; tick();
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL sat_drop_stall got=%b exp=0", bus.issue_stall); end
    checks++; if (bus.flags_ready !== 1'b0) begin errors++; $display("FAIL sat_drop_ready got=%b exp=0", bus.flags_ready); end
    bus.issue_set_flags = 1'b1; tick();
    checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL sat_refill_stall got=%b exp=1", bus.issue_stall); end
    for (int i = 0; i < 2; i++) begin
      bus.wb_flags_valid = 1'b1; tick();
    end
    checks++; if (bus.flags_ready !== 1'b0) begin errors++; $display("FAIL sat_drain2_ready got=%b exp=0", bus.flags_ready); end
    bus.wb_flags_valid = 1'b1; tick();
    checks++; if (bus.flags_ready !== 1'b1) begin errors++; $display("FAIL sat_drain3_ready got=%b exp=1", bus.flags_ready); end
    checks++; if (bus.cpsr !== 32'hE000_00D3) begin errors++; $display("FAIL sat_cpsr got=%h exp=%h", bus.cpsr, 32'hE000_00D3); end
  endtask

  task automatic test_exception();
    bus.msr_valid = 1'b1; bus.msr_spsr = 1'b0; bus.msr_field = 4'b1001; bus.msr_data = 32'h0000_0010; tick();
    checks++; if (bus.cpsr !== 32'h0000_0010) begin errors++; $display("FAIL exc_msr_cpsr got=%h exp=%h", bus.cpsr, 32'h0000_0010); end
    bus.issue_set_flags = 1'b1; tick();
    bus.issue_set_flags = 1'b1;
    bus.wb_flags_valid = 1'b1; bus.wb_flags = 4'b0100; bus.wb_mask = 4'b1111;
    bus.exc_valid = 1'b1; bus.exc_mode = 5'b10010; tick();
    checks++; if (bus.spsr !== 32'h4000_0010) begin errors++; $display("FAIL exc_spsr got=%h exp=%h", bus.spsr, 32'h4000_0010); end
    checks++; if (bus.cpsr !== 32'h4000_0092) begin errors++; $display("FAIL exc_cpsr got=%h exp=%h", bus.cpsr, 32'h4000_0092); end
    checks++; if (bus.flags_ready !== 1'b1) begin errors++; $display("FAIL exc_ready got=%b exp=1", bus.flags_ready); end
  endtask

  task automatic test_msr_restore();
    bus.msr_valid = 1'b1; bus.msr_spsr = 1'b1; bus.msr_field = 4'b1001; bus.msr_data = 32'hF000_001F; tick();
    checks++; if (bus.spsr !== 32'hF000_001F) begin errors++; $display("FAIL msr_spsr got=%h exp=%h", bus.spsr, 32'hF000_001F); end
    checks++; if (bus.cpsr !== 32'h4000_0092) begin errors++; $display("FAIL msr_cpsr_kept got=%h exp=%h", bus.cpsr, 32'h4000_0092); end
    bus.spsr_restore = 1'b1; tick();
    checks++; if (bus.cpsr !== 32'hF000_001F) begin errors++; $display("FAIL restore_cpsr got=%h exp=%h", bus.cpsr, 32'hF000_001F); end
  endtask

  task automatic test_flush_underflow();
    for (int i = 0; i < 2; i++) begin
      bus.issue_set_flags = 1'b1; tick();
    end
    checks++; if (bus.flags_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_ready got=%b exp=0", bus.flags_ready); end
    bus.flush = 1'b1; bus.issue_set_flags = 1'b1; tick();
    checks++; if (bus.flags_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", bus.flags_ready); end
    bus.wb_flags_valid = 1'b1; bus.wb_flags = 4'b1010; bus.wb_mask = 4'b1111; tick();
    checks++; if (bus.cpsr !== 32'hA000_001F) begin errors++; $display("FAIL uflow_cpsr got=%h exp=%h", bus.cpsr, 32'hA000_001F); end
    checks++; if (bus.flags_ready !== 1'b1) begin errors++; $display("FAIL uflow_ready got=%b exp=1", bus.flags_ready); end
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL uflow_stall got=%b exp=0", bus.issue_stall); end
  endtask

  task automatic test_async_reset();
    bus.issue_set_flags = 1'b1; tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.cpsr !== 32'h0000_00D3) begin errors++; $display("FAIL areset_cpsr got=%h exp=%h", bus.cpsr, 32'h0000_00D3); end
    checks++; if (bus.flags_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%b exp=1", bus.flags_ready); end
    checks++; if (bus.spsr !== 32'h0) begin errors++; $display("FAIL areset_spsr got=%h exp=0", bus.spsr); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_masked_wb();
    test_saturation();
    test_exception();
    test_msr_restore();
    test_flush_underflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
